matrix_scan_controller: RTL and testbench

Sequences the 5x7 LED matrix column scan.
- Generates the one-hot column strobe and the matching 7-bit row pattern.
- Inserts a blanking gap between columns to suppress ghosting.
- Double-buffers frame data behind a valid/ready handshake, so a new frame takes effect only at a frame boundary.
- Sits between the display/game logic (frame producer) and the matrix pins.

---
 rtl/matrix_scan_controller_pkg.sv | 30 +++
 rtl/matrix_scan_controller_if.sv | 24 ++
 rtl/matrix_scan_controller_scan_timer.sv | 33 +++
 rtl/matrix_scan_controller.sv | 162 ++++++++++++++++
 tb/tb_matrix_scan_controller.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/matrix_scan_controller_pkg.sv
// Shared constants, scan state encoding and frame slicing helper for the
// 5x7 LED matrix column scanner.
package matrix_pkg;

    localparam int MATRIX_COLUMNS = 5;
    localparam int MATRIX_ROWS    = 7;
    localparam int FRAME_WIDTH    = MATRIX_COLUMNS * MATRIX_ROWS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_t;

    // Out-of-range column indices yield a dark column rather than X.
    function automatic logic [MATRIX_ROWS-1:0] column_slice(
        input logic [FRAME_WIDTH-1:0] frame,
        input logic [2:0]             k
    );
        logic [MATRIX_ROWS-1:0] slice;
        slice = '0;
        for (int i = 0; i < MATRIX_COLUMNS; i++) begin
            if (k == 3'(i)) begin
                slice = frame[i*MATRIX_ROWS +: MATRIX_ROWS];
            end
        end
        return slice;
    endfunction

endpackage

// File: rtl/matrix_scan_controller_if.sv
// Frame handshake and matrix pin bundle between the frame producer (master)
// and the scan controller (slave).
interface matrix_scan_controller_if;
    import matrix_pkg::*;

    logic                      enable;
    logic [FRAME_WIDTH-1:0]    frame_data;
    logic                      frame_valid;
    logic                      frame_ready;
    logic [MATRIX_COLUMNS-1:0] column_enable;
    logic [MATRIX_ROWS-1:0]    row_out;
    logic                      blanking;
    logic                      frame_start;

    modport master (
        output enable, frame_data, frame_valid,
        input  frame_ready, column_enable, row_out, blanking, frame_start
    );

    modport slave (
        input  enable, frame_data, frame_valid,
        output frame_ready, column_enable, row_out, blanking, frame_start
    );
endinterface

// File: rtl/matrix_scan_controller_scan_timer.sv
// Loadable down-counter shared by the blank and dwell intervals; holds at
// zero until reloaded.
module scan_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);
endmodule

// File: rtl/matrix_scan_controller.sv
// Column scan sequencer for a 5x7 LED matrix with blanking gaps and a
// double-buffered frame that swaps only at frame boundaries.
module matrix_scan_controller
    import matrix_pkg::*;
#(
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 8,
    parameter int COLUMNS      = MATRIX_COLUMNS,
    parameter int ROWS         = MATRIX_ROWS
) (
    input  logic                      clock,
    input  logic                      reset,
    matrix_scan_controller_if.slave   bus
);
    localparam int MAX_INTERVAL = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int TIMER_WIDTH  = $clog2(MAX_INTERVAL + 1);

    scan_state_t            state_q;
    logic [2:0]             index_q;
    logic [COLUMNS-1:0]     column_enable_q;
    logic [ROWS-1:0]        row_out_q;
    logic                   blanking_q;
    logic                   frame_start_q;

    logic [FRAME_WIDTH-1:0] display_q;
    logic [FRAME_WIDTH-1:0] pending_q;
    logic                   pending_full_q;

    logic                   timer_zero;
    logic                   timer_load;
    logic [TIMER_WIDTH-1:0] timer_value;
    logic                   frame_boundary;
    logic                   capture;
    logic [COLUMNS-1:0]     column_onehot;

    generate
        for (genvar gi = 0; gi < COLUMNS; gi++) begin : g_onehot
            assign column_onehot[gi] = (index_q == 3'(gi));
        end
    endgenerate

    // frame_boundary marks the edge that enters BLANK of column 0.
    always_comb begin
        timer_load     = 1'b1;
        timer_value    = '0;
        frame_boundary = 1'b0;
        if (bus.enable) begin
            case (state_q)
                IDLE: begin
                    timer_value    = TIMER_WIDTH'(BLANK_CYCLES - 1);
                    frame_boundary = 1'b1;
                end
                BLANK: begin
                    timer_load  = timer_zero;
                    timer_value = TIMER_WIDTH'(DWELL_CYCLES - 1);
                end
                DRIVE: begin
                    timer_load     = timer_zero;
                    timer_value    = TIMER_WIDTH'(BLANK_CYCLES - 1);
                    frame_boundary = timer_zero && (index_q >= 3'(COLUMNS - 1));
                end
                default: begin
                    timer_value = '0;
                end
            endcase
        end
    end

    scan_timer #(
        .WIDTH (TIMER_WIDTH)
    ) u_scan_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .zero       (timer_zero)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            index_q         <= '0;
            column_enable_q <= '0;
            row_out_q       <= '0;
            blanking_q      <= 1'b1;
            frame_start_q   <= 1'b0;
        end else if (!bus.enable) begin
            state_q         <= IDLE;
            index_q         <= '0;
            column_enable_q <= '0;
            row_out_q       <= '0;
            blanking_q      <= 1'b1;
            frame_start_q   <= 1'b0;
        end else begin
            frame_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    state_q         <= BLANK;
                    index_q         <= '0;
                    column_enable_q <= '0;
                    row_out_q       <= '0;
                    blanking_q      <= 1'b1;
                    frame_start_q   <= 1'b1;
                end
                BLANK: begin
                    if (timer_zero) begin
                        state_q         <= DRIVE;
                        column_enable_q <= column_onehot;
                        row_out_q       <= column_slice(display_q, index_q);
                        blanking_q      <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (timer_zero) begin
                        state_q         <= BLANK;
                        column_enable_q <= '0;
                        row_out_q       <= '0;
                        blanking_q      <= 1'b1;
                        if (frame_boundary) begin
                            index_q       <= '0;
                            frame_start_q <= 1'b1;
                        end else begin
                            index_q <= index_q + 3'd1;
                        end
                    end
                end
                default: begin
                    state_q         <= IDLE;
                    index_q         <= '0;
                    column_enable_q <= '0;
                    row_out_q       <= '0;
                    blanking_q      <= 1'b1;
                end
            endcase
        end
    end

    // Capture needs an empty pending slot, so it never collides with a swap.
    assign capture = bus.frame_valid && !pending_full_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            display_q      <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
        end else begin
            if (frame_boundary && pending_full_q) begin
                display_q <= pending_q;
            end
            if (capture) begin
                pending_q <= bus.frame_data;
            end
            pending_full_q <= capture || (pending_full_q && !frame_boundary);
        end
    end

    assign bus.frame_ready   = !pending_full_q;
    assign bus.column_enable = column_enable_q;
    assign bus.row_out       = row_out_q;
    assign bus.blanking      = blanking_q;
    assign bus.frame_start   = frame_start_q;
endmodule

// File: tb/tb_matrix_scan_controller.sv
// Directed plus randomized bench for the matrix scan controller, checked
// against a time-position model of the scan and the two frame buffers.
module tb_matrix_scan_controller;
    import matrix_pkg::*;

    localparam int DWELL  = 4;
    localparam int BLNK   = 2;
    localparam int PERIOD = DWELL + BLNK;
    localparam int FRAME  = MATRIX_COLUMNS * PERIOD;

    logic clock = 1'b0;
    logic reset = 1'b1;

    matrix_scan_controller_if bus ();

    matrix_scan_controller #(
        .DWELL_CYCLES (DWELL),
        .BLANK_CYCLES (BLNK),
        .COLUMNS      (MATRIX_COLUMNS),
        .ROWS         (MATRIX_ROWS)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    // Model: position within the frame since scanning began, plus buffers.
    bit                     m_running = 1'b0;
    int                     m_t       = 0;
    logic [FRAME_WIDTH-1:0] m_disp    = '0;
    logic [FRAME_WIDTH-1:0] m_pend    = '0;
    bit                     m_full    = 1'b0;

    task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cycle, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit boundary;
        bit cap;
        if (reset) begin
            m_running = 1'b0;
            m_t       = 0;
            m_disp    = '0;
            m_pend    = '0;
            m_full    = 1'b0;
        end else begin
            boundary = bus.enable && (!m_running || (m_t == FRAME - 1));
            cap      = bus.frame_valid && !m_full;
            if (boundary && m_full) begin
                m_disp = m_pend;
                m_full = 1'b0;
            end
            if (cap) begin
                m_pend = bus.frame_data;
                m_full = 1'b1;
                $display("cycle %0d capture frame=%h", cycle, bus.frame_data);
            end
            if (!bus.enable) begin
                m_running = 1'b0;
                m_t       = 0;
            end else if (!m_running) begin
                m_running = 1'b1;
                m_t       = 0;
            end else begin
                m_t = (m_t + 1) % FRAME;
            end
        end
    endtask

    task automatic check_all();
        logic [4:0] ce;
        logic [6:0] row;
        logic       blank;
        logic       fs;
        int col;
        int w;
        ce = '0; row = '0; blank = 1'b1; fs = 1'b0;
        if (m_running) begin
            col = m_t / PERIOD;
            w   = m_t % PERIOD;
            fs  = (m_t == 0);
            if (w >= BLNK) begin
                blank = 1'b0;
                ce    = 5'(1 << col);
                row   = m_disp[col*7 +: 7];
            end
        end
        chk("column_enable", 35'(bus.column_enable), 35'(ce));
        chk("row_out",       35'(bus.row_out),       35'(row));
        chk("blanking",      35'(bus.blanking),      35'(blank));
        chk("frame_start",   35'(bus.frame_start),   35'(fs));
        chk("frame_ready",   35'(bus.frame_ready),   35'(!m_full));
    endtask

    task automatic step();
        @(posedge clock);
        cycle++;
        model_edge();
        #1;
        check_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Advance until the model sits at frame position lo..hi, bounded.
    task automatic run_until(input int lo, input int hi, input string tag);
        int n = 0;
        while (!(m_running && m_t >= lo && m_t <= hi) && n < 3 * FRAME) begin
            step();
            n++;
        end
        chk(tag, 35'(m_running && m_t >= lo && m_t <= hi), 35'(1));
    endtask

    initial begin
        logic [FRAME_WIDTH-1:0] f;
        bus.enable      = 1'b0;
        bus.frame_valid = 1'b0;
        bus.frame_data  = '0;

        // Reset state
        steps(2);
        reset = 1'b0;
        steps(2);

        // Free-running scan with an empty display
        bus.enable = 1'b1;
        steps(2 * FRAME + 5);

        // Load all-ones frame while idle, then scan it
        bus.enable = 1'b0;
        steps(2);
        bus.frame_data  = 35'h7FFFFFFFF;
        bus.frame_valid = 1'b1;
        step();
        bus.frame_valid = 1'b0;
        bus.frame_data  = '0;
        steps(3);
        bus.enable = 1'b1;
        steps(FRAME + 3);

        // New frame with column 2 = 0x55 offered during column 1
        run_until(PERIOD + BLNK, 2 * PERIOD - 1, "reach_col1");
        f = 35'h7FFFFFFFF;
        f[14 +: 7] = 7'h55;
        bus.frame_data  = f;
        bus.frame_valid = 1'b1;
        step();
        // Held valid while pending is full: no further capture
        bus.frame_data = 35'h123456789;
        steps(6);
        bus.frame_valid = 1'b0;
        steps(2 * FRAME);

        // Capture exactly on the frame_start edge
        run_until(FRAME - 1, FRAME - 1, "reach_frame_end");
        bus.frame_data  = 35'h2AAAAAAAA;
        bus.frame_valid = 1'b1;
        step();
        bus.frame_valid = 1'b0;
        steps(2 * FRAME);

        // Drop enable during column 3 drive, then restart
        run_until(3 * PERIOD + BLNK, 4 * PERIOD - 1, "reach_col3");
        bus.enable = 1'b0;
        steps(3);
        bus.enable = 1'b1;
        steps(FRAME);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bus.enable      = ($urandom_range(0, 19) != 0);
            bus.frame_valid = ($urandom_range(0, 5) == 0);
            bus.frame_data  = 35'({$urandom, $urandom});
            reset           = ($urandom_range(0, 149) == 0);
            step();
        end
        reset           = 1'b0;
        bus.frame_valid = 1'b0;

        // Reset during drive with a pending frame, then confirm display is dark
        bus.enable = 1'b1;
        bus.frame_data  = 35'h7FFFFFFFF;
        bus.frame_valid = 1'b1;
        step();
        bus.frame_valid = 1'b0;
        step();
        if (!m_full) begin
            bus.frame_valid = 1'b1;
            step();
            bus.frame_valid = 1'b0;
        end
        run_until(PERIOD + BLNK, 2 * PERIOD - 1, "reach_drive_pre_reset");
        chk("pending_before_reset", 35'(bus.frame_ready), 35'(0));
        reset = 1'b1;
        step();
        reset = 1'b0;
        steps(FRAME + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
